// File: rtl/rr_multichannel_recorder.sv
// rr_multichannel_recorder: N-channel record stage. Each channel is a
// valid/ready stream buffered by its own FIFO; all beats accepted in a cycle
// are coalesced into one log record, and a stalled log bus blocks acceptance
// so no event is lost.
module rr_multichannel_recorder #(
  parameter int unsigned        CH_CNT     = 5,
  parameter int unsigned        DATA_W     = 64,
  parameter logic [CH_CNT-1:0]  LOGB_MASK  = '1,
  parameter int unsigned        PIPE_DEPTH = 4,
  parameter int unsigned        CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       sync_rst,
  input  logic                       record_en,
  input  logic [CH_CNT-1:0]          in_valid,
  output logic [CH_CNT-1:0]          in_ready,
  input  logic [CH_CNT*DATA_W-1:0]   in_data,
  output logic [CH_CNT-1:0]          out_valid,
  input  logic [CH_CNT-1:0]          out_ready,
  output logic [CH_CNT*DATA_W-1:0]   out_data,
  output logic [CH_CNT-1:0]          loge_valid,
  output logic [CH_CNT-1:0]          logb_valid,
  output logic [CH_CNT*DATA_W-1:0]   logb_data,
  output logic                       log_valid,
  input  logic                       log_ready,
  output logic [CH_CNT*CNT_W-1:0]    evt_cnt
);

  localparam int unsigned PTR_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [CH_CNT-1:0]        w_fire;
  logic [CH_CNT-1:0]        w_full;
  logic [CH_CNT-1:0]        w_pop;
  logic                     w_stall_n;
  logic [CH_CNT*DATA_W-1:0] w_logb_next;
  logic [CH_CNT-1:0]        r_loge;
  logic [CH_CNT*DATA_W-1:0] r_logb_data;

  // A pending record that the log bus will not take this cycle blocks every
  // channel; in pass-through mode the log register never fills from fires.
  assign w_stall_n  = ~log_valid | log_ready | ~record_en;
  assign in_ready   = ~w_full & {CH_CNT{w_stall_n & ~sync_rst}};
  assign w_fire     = in_valid & in_ready;

  assign loge_valid = r_loge;
  assign logb_valid = r_loge & LOGB_MASK;
  assign logb_data  = r_logb_data;
  assign log_valid  = |r_loge;

  for (genvar g = 0; g < CH_CNT; g++) begin : g_ch
    logic [DATA_W-1:0] r_mem [PIPE_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_evt;

    assign w_full[g]                       = (r_occ == OCC_W'(PIPE_DEPTH));
    assign out_valid[g]                    = (r_occ != '0);
    assign out_data[g*DATA_W +: DATA_W]    = r_mem[r_rd_ptr];
    assign w_pop[g]                        = out_valid[g] & out_ready[g];
    assign evt_cnt[g*CNT_W +: CNT_W]       = r_evt;
    assign w_logb_next[g*DATA_W +: DATA_W] = (w_fire[g] && LOGB_MASK[g]) ?
                                             in_data[g*DATA_W +: DATA_W] : '0;

    // FIFO storage write; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
      if (w_fire[g]) begin
        r_mem[r_wr_ptr] <= in_data[g*DATA_W +: DATA_W];
      end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
      if (sync_rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_fire[g]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_fire[g], w_pop[g]})
          2'b10:   r_occ <= r_occ + OCC_W'(1);
          2'b01:   r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end

    // Per-channel logged-beat counter, wraps freely
    always_ff @(posedge clk) begin
      if (sync_rst) begin
        r_evt <= '0;
      end else if (w_fire[g] && record_en) begin
        r_evt <= r_evt + CNT_W'(1);
      end
    end
  end

  // Log record: new fires load with no bubble, otherwise drain on log_ready
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_loge      <= '0;
      r_logb_data <= '0;
    end else if (record_en && (|w_fire)) begin
      r_loge      <= w_fire;
      r_logb_data <= w_logb_next;
    end else if (log_ready) begin
      r_loge      <= '0;
      r_logb_data <= '0;
    end
  end

endmodule

// File: tb/tb_rr_multichannel_recorder.sv
// Bench for rr_multichannel_recorder: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the record stage.
module tb_rr_multichannel_recorder;

  localparam int unsigned CH    = 5;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;
  localparam logic [CH-1:0] MASK = 5'b00111;

  logic              clk = 1'b0;
  logic              sync_rst;
  logic              record_en;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [CH*DW-1:0]  in_data;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready;
  logic [CH*DW-1:0]  out_data;
  logic [CH-1:0]     loge_valid;
  logic [CH-1:0]     logb_valid;
  logic [CH*DW-1:0]  logb_data;
  logic              log_valid;
  logic              log_ready;
  logic [CH*CW-1:0]  evt_cnt;

  int errors = 0;
  int checks = 0;

  rr_multichannel_recorder #(
    .CH_CNT(CH), .DATA_W(DW), .LOGB_MASK(MASK), .PIPE_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clk(clk), .sync_rst(sync_rst), .record_en(record_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .loge_valid(loge_valid), .logb_valid(logb_valid), .logb_data(logb_data),
    .log_valid(log_valid), .log_ready(log_ready), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: one queue per channel, the pending record, counters
  logic [DW-1:0]    mq [CH][$];
  logic [CH-1:0]    m_loge;
  logic [CH*DW-1:0] m_logb;
  logic [CW-1:0]    m_cnt [CH];

  function automatic logic [CH-1:0] exp_ready();
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++)
      r[i] = !sync_rst && (mq[i].size() < DEPTH) &&
             (m_loge == '0 || log_ready || !record_en);
    return r;
  endfunction

  function automatic logic [CH*CW-1:0] exp_cnt();
    logic [CH*CW-1:0] v;
    for (int i = 0; i < CH; i++) v[i*CW +: CW] = m_cnt[i];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_ovalid();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  // Advance one clock and the model with it; returns #1 after the edge
  task automatic tick();
    logic [CH-1:0] fire;
    logic [CH-1:0] pop;
    fire = in_valid & exp_ready();
    for (int i = 0; i < CH; i++) pop[i] = (mq[i].size() != 0) && out_ready[i];
    @(posedge clk);
    if (sync_rst) begin
      for (int i = 0; i < CH; i++) begin
        mq[i].delete();
        m_cnt[i] = '0;
      end
      m_loge = '0;
      m_logb = '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (pop[i]) void'(mq[i].pop_front());
        if (fire[i]) mq[i].push_back(in_data[i*DW +: DW]);
        if (fire[i] && record_en) m_cnt[i] = m_cnt[i] + 1'b1;
      end
      if (record_en && fire != '0) begin
        m_loge = fire;
        for (int i = 0; i < CH; i++)
          m_logb[i*DW +: DW] = (fire[i] && MASK[i]) ? in_data[i*DW +: DW] : '0;
      end else if (log_ready) begin
        m_loge = '0;
        m_logb = '0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (log_valid !== 1'b0 || loge_valid !== '0 || logb_data !== '0) begin
      errors++; $display("FAIL reset_log got=%b/%b exp=0/0", log_valid, loge_valid); end
    checks++; if (evt_cnt !== '0) begin errors++; $display("FAIL reset_evt got=%h exp=0", evt_cnt); end
    sync_rst = 1'b0;
    #1;
    checks++; if (in_ready !== 5'h1f) begin errors++; $display("FAIL post_reset_ready got=%b exp=11111", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 5'b00001;
    in_data  = '0;
    in_data[63:0] = 64'hA5;
    tick();
    in_valid = '0;
    checks++; if (out_valid[0] !== 1'b1 || out_data[63:0] !== 64'hA5) begin
      errors++; $display("FAIL single_out got=%b/%h exp=1/a5", out_valid[0], out_data[63:0]); end
    checks++; if (loge_valid !== 5'b00001 || logb_data[63:0] !== 64'hA5) begin
      errors++; $display("FAIL single_log got=%b/%h exp=00001/a5", loge_valid, logb_data[63:0]); end
    checks++; if (evt_cnt[3:0] !== 4'd1) begin errors++; $display("FAIL single_evt got=%0d exp=1", evt_cnt[3:0]); end
    tick();
  endtask

  task automatic test_coalesce();
    in_valid = 5'b01010;
    for (int i = 0; i < CH; i++) in_data[i*DW +: DW] = {$urandom, $urandom};
    tick();
    in_valid = '0;
    checks++; if (loge_valid !== 5'b01010 || logb_valid !== 5'b00010 || log_valid !== 1'b1) begin
      errors++; $display("FAIL coalesce_bits got=%b/%b exp=01010/00010", loge_valid, logb_valid); end
    checks++; if (logb_data[3*DW +: DW] !== '0 || logb_data[1*DW +: DW] !== m_logb[1*DW +: DW]) begin
      errors++; $display("FAIL coalesce_lanes got=%h/%h exp=0/%h", logb_data[3*DW +: DW],
                         logb_data[1*DW +: DW], m_logb[1*DW +: DW]); end
    tick();
  endtask

  task automatic test_backpressure();
    log_ready = 1'b0;
    in_valid  = 5'b00001;
    in_data[63:0] = 64'h1234;
    tick();
    in_valid = 5'h1f;
    #1;
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_stall got=%b exp=00000", in_ready); end
    tick(); tick();
    checks++; if (loge_valid !== 5'b00001 || logb_data[63:0] !== 64'h1234) begin
      errors++; $display("FAIL bp_hold got=%b/%h exp=00001/1234", loge_valid, logb_data[63:0]); end
    checks++; if (evt_cnt !== exp_cnt()) begin errors++; $display("FAIL bp_evt got=%h exp=%h", evt_cnt, exp_cnt()); end
    log_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 5'h1f) begin errors++; $display("FAIL bp_resume got=%b exp=11111", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (loge_valid !== 5'h1f || logb_valid !== 5'b00111) begin
      errors++; $display("FAIL bp_record got=%b/%b exp=11111/00111", loge_valid, logb_valid); end
    checks++; if (out_valid !== exp_ovalid()) begin errors++; $display("FAIL bp_outv got=%b exp=%b", out_valid, exp_ovalid()); end
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] base;
    base = 64'hC0DE_0000;
    out_ready = 5'b11011;
    in_valid  = 5'b00101;
    for (int k = 0; k < 4; k++) begin
      in_data[2*DW +: DW] = base + DW'(k);
      in_data[0 +: DW]    = base + DW'(k + 16);
      tick();
    end
    checks++; if (in_ready[2] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL full_ready got=%b exp=xx0x1", in_ready); end
    out_ready[2] = 1'b1;
    #1;
    checks++; if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", in_ready[2]); end
    checks++; if (out_data[2*DW +: DW] !== base) begin
      errors++; $display("FAIL full_head0 got=%h exp=%h", out_data[2*DW +: DW], base); end
    tick();
    out_ready[2] = 1'b0;
    in_valid = '0;
    checks++; if (in_ready[2] !== 1'b1) begin errors++; $display("FAIL full_after_pop got=%b exp=1", in_ready[2]); end
    out_ready = 5'h1f;
    for (int k = 1; k < 4; k++) begin
      checks++; if (out_valid[2] !== 1'b1 || out_data[2*DW +: DW] !== base + DW'(k)) begin
        errors++; $display("FAIL full_order%0d got=%h exp=%h", k, out_data[2*DW +: DW], base + DW'(k)); end
      tick();
    end
    checks++; if (out_valid !== '0) begin errors++; $display("FAIL full_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_mode();
    logic [CH*CW-1:0] snap;
    snap = exp_cnt();
    record_en = 1'b0;
    in_valid  = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      in_data[DW +: DW] = 64'hBEEF_0000 + DW'(k);
      tick();
      checks++; if (log_valid !== 1'b0 || out_valid[1] !== 1'b1 ||
                    out_data[DW +: DW] !== 64'hBEEF_0000 + DW'(k)) begin
        errors++; $display("FAIL mode_beat%0d got=%b/%b/%h exp=0/1/%h", k, log_valid, out_valid[1],
                           out_data[DW +: DW], 64'hBEEF_0000 + DW'(k)); end
    end
    in_valid = '0;
    tick();
    record_en = 1'b1;
    checks++; if (evt_cnt !== snap) begin errors++; $display("FAIL mode_evt got=%h exp=%h", evt_cnt, snap); end
  endtask

  task automatic test_wrap();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    in_valid = 5'b10000;
    for (int k = 0; k < 17; k++) begin
      in_data[4*DW +: DW] = DW'(k);
      tick();
    end
    in_valid = '0;
    checks++; if (evt_cnt !== 20'h10000) begin errors++; $display("FAIL wrap_evt got=%h exp=10000", evt_cnt); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = '0;
    log_ready = 1'b1;
    in_valid  = 5'b00001;
    tick(); tick();
    in_valid  = '0;
    log_ready = 1'b0;
    tick();
    checks++; if (log_valid !== 1'b1 || out_valid[0] !== 1'b1) begin
      errors++; $display("FAIL mid_pre got=%b/%b exp=1/1", log_valid, out_valid[0]); end
    sync_rst = 1'b1;
    tick();
    checks++; if (out_valid !== '0 || log_valid !== 1'b0 || evt_cnt !== '0 || in_ready !== '0) begin
      errors++; $display("FAIL mid_reset got=%b/%b/%h/%b exp=0/0/0/0", out_valid, log_valid, evt_cnt, in_ready); end
    sync_rst  = 1'b0;
    out_ready = 5'h1f;
    log_ready = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = CH'($urandom);
      out_ready = CH'($urandom) | CH'($urandom);
      log_ready = ($urandom_range(0, 3) != 0);
      record_en = ($urandom_range(0, 7) != 0);
      sync_rst  = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < CH; i++) in_data[i*DW +: DW] = {$urandom, $urandom};
      #1;
      checks++; if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready()); end
      tick();
      checks++; if (out_valid !== exp_ovalid()) begin
        errors++; $display("FAIL rnd_outv c=%0d got=%b exp=%b", c, out_valid, exp_ovalid()); end
      for (int i = 0; i < CH; i++) begin
        if (mq[i].size() != 0) begin
          checks++; if (out_data[i*DW +: DW] !== mq[i][0]) begin
            errors++; $display("FAIL rnd_data c=%0d ch=%0d got=%h exp=%h", c, i, out_data[i*DW +: DW], mq[i][0]); end
        end
      end
      checks++; if (loge_valid !== m_loge || logb_valid !== (m_loge & MASK) || log_valid !== (m_loge != '0)) begin
        errors++; $display("FAIL rnd_log c=%0d got=%b/%b exp=%b", c, loge_valid, logb_valid, m_loge); end
      checks++; if (logb_data !== m_logb) begin errors++; $display("FAIL rnd_logb c=%0d", c); end
      checks++; if (evt_cnt !== exp_cnt()) begin
        errors++; $display("FAIL rnd_evt c=%0d got=%h exp=%h", c, evt_cnt, exp_cnt()); end
    end
    sync_rst = 1'b0;
  endtask

  initial begin
    sync_rst  = 1'b1;
    record_en = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 5'h1f;
    log_ready = 1'b1;
    m_loge    = '0;
    m_logb    = '0;
    for (int i = 0; i < CH; i++) m_cnt[i] = '0;
    test_reset();
    test_single();
    test_coalesce();
    test_backpressure();
    test_fifo_full();
    test_mode();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
